// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator controller: key codes,
// controller states and key classification helpers.
package calc_pkg;

    localparam logic [3:0] KEY_EQ  = 4'hA;
    localparam logic [3:0] KEY_AC  = 4'hB;
    localparam logic [3:0] KEY_ADD = 4'hC;
    localparam logic [3:0] KEY_SUB = 4'hD;
    localparam logic [3:0] KEY_MUL = 4'hE;
    localparam logic [3:0] KEY_DIV = 4'hF;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        SHOW_RES,
        ERROR
    } calc_state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return k inside {KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV};
    endfunction

endpackage

// File: rtl/calc_digit_accum.sv
// Decimal digit accumulator: computes acc*10+digit and decides whether the
// digit may be appended (digit-count limit and W-bit overflow).
module calc_digit_accum #(
    parameter int W          = 16,
    parameter int MAX_DIGITS = 4,
    parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic [W-1:0]  acc,
    input  logic [CW-1:0] cnt,
    input  logic [3:0]    digit,
    output logic [W-1:0]  acc_next,
    output logic [CW-1:0] cnt_next,
    output logic          accept
);

    logic [W+3:0] wide;

    // acc*10 as (acc<<3)+(acc<<1); four guard bits always hold the full product
    always_comb begin
        wide     = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + {{W{1'b0}}, digit};
        accept   = (cnt < CW'(MAX_DIGITS)) && (wide[W+3:W] == 4'd0);
        acc_next = accept ? wide[W-1:0] : acc;
        cnt_next = accept ? cnt + CW'(1) : cnt;
    end

endmodule

// File: rtl/calc_ctrl_fsm.sv
// Keypad-to-ALU calculator controller: operand entry, ALU start/done
// handshake with timeout, chained operations, repeat-equals and error state.
module calc_ctrl_fsm
    import calc_pkg::*;
#(
    parameter int W          = 16,
    parameter int MAX_DIGITS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_op,
    output logic         alu_start,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    input  logic         alu_err,
    output logic [W-1:0] display,
    output logic         err,
    output logic         busy
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    calc_state_e   state, state_nxt;
    logic [W-1:0]  a, a_nxt;
    logic [W-1:0]  b, b_nxt;
    logic [W-1:0]  res, res_nxt;
    logic [W-1:0]  disp_q, disp_nxt;
    logic [CW-1:0] a_cnt, a_cnt_nxt;
    logic [CW-1:0] b_cnt, b_cnt_nxt;
    logic [3:0]    op, op_nxt;
    logic [3:0]    pend_op, pend_op_nxt;
    logic          chain, chain_nxt;
    logic          start_q, start_nxt;
    logic [TW-1:0] timer, timer_nxt;

    logic [W-1:0]  acc_in, acc_out;
    logic [CW-1:0] cnt_in, cnt_out;
    logic          accept;

    assign acc_in = (state == ENTER_B) ? b : a;
    assign cnt_in = (state == ENTER_B) ? b_cnt : a_cnt;

    calc_digit_accum #(
        .W          (W),
        .MAX_DIGITS (MAX_DIGITS),
        .CW         (CW)
    ) u_accum (
        .acc      (acc_in),
        .cnt      (cnt_in),
        .digit    (key_code),
        .acc_next (acc_out),
        .cnt_next (cnt_out),
        .accept   (accept)
    );

    assign alu_a     = a;
    assign alu_b     = b;
    assign alu_op    = op;
    assign alu_start = start_q;
    assign display   = disp_q;
    assign err       = (state == ERROR);
    assign busy      = (state == EXEC);

    // State and datapath registers; everything returns to idle values on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ENTER_A;
            a       <= '0;
            b       <= '0;
            res     <= '0;
            disp_q  <= '0;
            a_cnt   <= '0;
            b_cnt   <= '0;
            op      <= KEY_ADD;
            pend_op <= KEY_ADD;
            chain   <= 1'b0;
            start_q <= 1'b0;
            timer   <= '0;
        end else begin
            state   <= state_nxt;
            a       <= a_nxt;
            b       <= b_nxt;
            res     <= res_nxt;
            disp_q  <= disp_nxt;
            a_cnt   <= a_cnt_nxt;
            b_cnt   <= b_cnt_nxt;
            op      <= op_nxt;
            pend_op <= pend_op_nxt;
            chain   <= chain_nxt;
            start_q <= start_nxt;
            timer   <= timer_nxt;
        end
    end

    // Next-state, operand and display logic; entering EXEC arms the start pulse and timer
    always_comb begin
        state_nxt   = state;
        a_nxt       = a;
        b_nxt       = b;
        res_nxt     = res;
        a_cnt_nxt   = a_cnt;
        b_cnt_nxt   = b_cnt;
        op_nxt      = op;
        pend_op_nxt = pend_op;
        chain_nxt   = chain;
        start_nxt   = 1'b0;
        timer_nxt   = timer;
        disp_nxt    = disp_q;

        case (state)
            ENTER_A: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (accept) begin
                            a_nxt     = acc_out;
                            a_cnt_nxt = cnt_out;
                        end
                    end else if (is_op(key_code)) begin
                        op_nxt    = key_code;
                        b_nxt     = '0;
                        b_cnt_nxt = '0;
                        state_nxt = ENTER_B;
                    end else if (key_code == KEY_AC) begin
                        a_nxt     = '0;
                        a_cnt_nxt = '0;
                    end
                end
            end

            ENTER_B: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (accept) begin
                            b_nxt     = acc_out;
                            b_cnt_nxt = cnt_out;
                        end
                    end else if (is_op(key_code)) begin
                        if (b_cnt == '0) begin
                            op_nxt = key_code;
                        end else begin
                            chain_nxt   = 1'b1;
                            pend_op_nxt = key_code;
                            state_nxt   = EXEC;
                            start_nxt   = 1'b1;
                            timer_nxt   = '0;
                        end
                    end else if (key_code == KEY_EQ) begin
                        chain_nxt = 1'b0;
                        if (b_cnt == '0) begin
                            b_nxt = '0;
                        end
                        state_nxt = EXEC;
                        start_nxt = 1'b1;
                        timer_nxt = '0;
                    end else begin
                        if (b_cnt != '0) begin
                            b_nxt     = '0;
                            b_cnt_nxt = '0;
                        end else begin
                            a_nxt     = '0;
                            b_nxt     = '0;
                            a_cnt_nxt = '0;
                            b_cnt_nxt = '0;
                            state_nxt = ENTER_A;
                        end
                    end
                end
            end

            EXEC: begin
                if (alu_done) begin
                    if (alu_err) begin
                        state_nxt = ERROR;
                    end else if (chain) begin
                        a_nxt     = alu_result;
                        op_nxt    = pend_op;
                        b_nxt     = '0;
                        b_cnt_nxt = '0;
                        state_nxt = ENTER_B;
                    end else begin
                        res_nxt   = alu_result;
                        state_nxt = SHOW_RES;
                    end
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_nxt = ERROR;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end

            SHOW_RES: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        a_nxt     = W'(key_code);
                        a_cnt_nxt = CW'(1);
                        state_nxt = ENTER_A;
                    end else if (is_op(key_code)) begin
                        a_nxt     = res;
                        op_nxt    = key_code;
                        b_nxt     = '0;
                        b_cnt_nxt = '0;
                        state_nxt = ENTER_B;
                    end else if (key_code == KEY_EQ) begin
                        a_nxt     = res;
                        chain_nxt = 1'b0;
                        state_nxt = EXEC;
                        start_nxt = 1'b1;
                        timer_nxt = '0;
                    end else begin
                        a_nxt     = '0;
                        b_nxt     = '0;
                        a_cnt_nxt = '0;
                        b_cnt_nxt = '0;
                        state_nxt = ENTER_A;
                    end
                end
            end

            ERROR: begin
                if (key_valid && key_code == KEY_AC) begin
                    a_nxt     = '0;
                    b_nxt     = '0;
                    a_cnt_nxt = '0;
                    b_cnt_nxt = '0;
                    state_nxt = ENTER_A;
                end
            end

            default: begin
                state_nxt = ENTER_A;
            end
        endcase

        case (state_nxt)
            ENTER_A:  disp_nxt = a_nxt;
            ENTER_B:  disp_nxt = (b_cnt_nxt != '0) ? b_nxt : a_nxt;
            SHOW_RES: disp_nxt = res_nxt;
            ERROR:    disp_nxt = '0;
            default:  disp_nxt = disp_q;
        endcase
    end

endmodule

// File: doc/calc_ctrl_fsm.md
Name: calc_ctrl_fsm

Overview:
Parametrised keypad-to-ALU calculator controller, the successor to the 16-bit negedge-strobed controller. It accepts synchronous key strobes and accumulates decimal operands in binary, with digit and overflow limits. It drives an external ALU through a start/done handshake with timeout, and supports chained operations, repeat-equals, clear-entry vs clear-all, and an error state. It sits between the keypad scanner and the ALU/display driver.

Parameters:
W, 16, operand/result/display width in bits.
MAX_DIGITS, 4, max decimal digits accepted per operand.
TIMEOUT, 255, max cycles to wait for alu_done before entering ERROR (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
key_valid  in  1  one-cycle strobe, key_code valid (already synchronised to clk).
key_code  in  4  0-9 digit, A equal, B AC, C plus, D minus, E mult, F div.
alu_a  out  W  operand A to ALU.
alu_b  out  W  operand B to ALU.
alu_op  out  4  operator code (C-F) to ALU.
alu_start  out  1  one-cycle request pulse.
alu_done  in  1  one-cycle completion pulse; alu_result/alu_err valid this cycle.
alu_result  in  W  ALU result.
alu_err  in  1  ALU error (e.g. divide by zero).
display  out  W  value to show.
err  out  1  high while in ERROR.
busy  out  1  high while in EXEC.

Behaviour:
- Reset: state ENTER_A; a, b, res, display = 0; a_cnt, b_cnt = 0; op = C (plus); alu_start, err, busy, chain = 0. alu_a, alu_b and alu_op are driven from the a, b and op registers.
- All updates are registered. A key strobed in cycle n takes effect in the state, registers and display at edge n+1.
- Digit append: new = acc*10 + d. The digit is ignored when cnt == MAX_DIGITS or new >= 2^W. Otherwise acc = new and cnt++. Leading zeros count as digits.
- ENTER_A:
  - digit: append to a.
  - operator: op = key, b = 0, b_cnt = 0, go to ENTER_B.
  - AC: a = 0, a_cnt = 0.
  - equal: ignored.
- ENTER_B:
  - digit: append to b.
  - operator with b_cnt == 0: replace op only.
  - operator with b_cnt > 0: chain = 1, pend_op = key, go to EXEC.
  - equal: chain = 0, go to EXEC (b = 0 if nothing was entered).
  - AC with b_cnt > 0: b = 0, b_cnt = 0 (clear entry).
  - AC with b_cnt == 0: clear a, b and counts, go to ENTER_A (clear all).
- EXEC:
  - alu_start = 1 for exactly the first cycle in EXEC. busy = 1. Keys are dropped. A timer counts cycles.
  - alu_done with alu_err = 1: go to ERROR.
  - alu_done, no error, chain = 1: a = alu_result, op = pend_op, b = 0, b_cnt = 0, go to ENTER_B.
  - alu_done, no error, chain = 0: res = alu_result, go to SHOW_RES.
  - Timer reaches TIMEOUT without alu_done: go to ERROR.
  - alu_done is ignored in any state other than EXEC.
- SHOW_RES:
  - digit: a = d, a_cnt = 1, go to ENTER_A.
  - operator: a = res, op = key, b = 0, b_cnt = 0, go to ENTER_B.
  - equal (repeat): a = res, b and op retained, chain = 0, go to EXEC.
  - AC: clear all, go to ENTER_A.
- ERROR: err = 1, display = 0. Only AC is accepted; it clears all and goes to ENTER_A.
- Display: ENTER_A shows a. ENTER_B shows b if b_cnt > 0, else a. EXEC holds its previous value. SHOW_RES shows res.
- Reset asserted mid-EXEC: everything returns to reset values immediately and any pending alu_done is ignored.
- key_valid in the same cycle as alu_done while in EXEC: the key is dropped and alu_done is processed.

Decomposition:
- Shared package calc_pkg: key code constants (KEY_EQ, KEY_AC, KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV), the state enum (ENTER_A, ENTER_B, EXEC, SHOW_RES, ERROR), and an is_digit/is_op helper.
- One sub-module, calc_digit_accum: combinational acc*10+d with overflow and MAX_DIGITS check, returning next acc, next cnt and accept. It is instantiated once and muxed on the active operand.

Test Plan:
- Keys 1,2,+,3,=; ALU returns 15 two cycles after start -> alu_a=12, alu_b=3, alu_op=C, one alu_start pulse, SHOW_RES, display=15.
- Keys 9,9,9,9,9 (MAX_DIGITS=4) -> a=9999, fifth digit ignored. With W=8 and keys 2,5,6 -> a=25 (256 rejected).
- Keys 5,+,3,*,2,= with ALU responding correctly -> first EXEC gives a=8, op=E; second gives display=16.
- Keys 8,/,0,=; ALU asserts alu_err -> err=1, display=0; digits ignored; AC -> ENTER_A, a=0, err=0.
- After result 15 (from 12+3), press = -> alu_a=15, alu_b=3, display=18. AC in ENTER_B with b_cnt>0 clears only b.
- ALU never responds (TIMEOUT=4) -> ERROR 4 cycles after alu_start. rst_n low mid-EXEC -> all outputs return to reset values asynchronously.
